pmu_quota_sched: RTL
====================

// Module: pmu_quota_sched
// PURPOSE
//  Time-multiplexed quota scheduler for the PMU. One shared accumulator/comparator
//  serves N_CORES cores. Cores are checked one after another, round-robin.
//  For each core, the block sums the counter values selected by that core's quota
//  mask and compares the sum against that core's limit. Over-quota results drive
//  sticky per-core interrupts.
//  Sits between the PMU counter bank/config registers and the interrupt lines.
// PARAMETERS
//  REG_WIDTH   32  width of each counter and of each quota limit
//  N_COUNTERS  9   number of shared event counters
//  N_CORES     4   number of cores sharing the quota datapath
//  SUM_W       REG_WIDTH+$clog2(N_COUNTERS) (local); accumulator width, cannot overflow
// PORTS
//  clk_i            in   1                     clock
//  rstn_i           in   1                     reset, asynchronous, active-low
//  en_i             in   1                     scheduler enable
//  softrst_i        in   1                     synchronous soft reset, active-high
//  counter_value_i  in   REG_WIDTH x N_COUNTERS  live counter values
//  quota_limit_i    in   REG_WIDTH x N_CORES     per-core quota limit
//  quota_mask_i     in   N_COUNTERS x N_CORES    per-core counter select mask
//  intr_quota_o     out  N_CORES               sticky per-core quota interrupt
//  done_o           out  1                     one-cycle pulse: a core check completed
//  done_core_o      out  $clog2(N_CORES)>0?..:1  index of the completed core
//  sum_o            out  SUM_W                 sum of the completed check
// BEHAVIOUR
//  Reset (rstn_i=0, async): state=IDLE, core_idx=0, cnt_idx=0, acc=0.
//   All outputs are 0: intr_quota_o, done_o, done_core_o, sum_o.
//  FSM states: IDLE, CLEAR, ACCUM, CHECK.
//   IDLE : when en_i=1 -> CLEAR with core_idx=0.
//   CLEAR: acc<=0; cnt_idx<=0.
//          Snapshot quota_mask_i[core_idx] -> mask_q and quota_limit_i[core_idx] -> lim_q.
//          -> ACCUM.
//   ACCUM: acc <= acc + (mask_q[cnt_idx] ? zero-extended counter_value_i[cnt_idx] : 0).
//          Counter values are sampled live, one per cycle.
//          cnt_idx==N_COUNTERS-1 -> CHECK; else cnt_idx++.
//   CHECK: on the closing edge:
//          intr_quota_o[core_idx] |= (acc > zero-extended lim_q)  (strict greater-than);
//          done_o<=1; done_core_o<=core_idx; sum_o<=acc.
//          core_idx wraps from N_CORES-1 to 0; else core_idx++.
//          -> CLEAR.
//  done_o is registered: high exactly the cycle after CHECK, otherwise 0.
//   In that same cycle sum_o, done_core_o and the updated interrupt bit are valid.
//   sum_o and done_core_o hold until the next done_o.
//  Timing: per-core check = N_COUNTERS+2 cycles; full sweep = N_CORES*(N_COUNTERS+2).
//   First done_o comes N_COUNTERS+2 cycles after the edge that samples en_i=1 in IDLE.
//  Mask/limit changes take effect at that core's next CLEAR. An in-flight check uses its snapshot.
//  en_i=0 in any non-IDLE state: next state IDLE, partial acc discarded, no done_o.
//   Interrupts are retained. Re-enabling restarts at core 0.
//  softrst_i=1, which has priority over en_i:
//   clears intr_quota_o, sum_o, done_core_o, done_o, acc;
//   state=IDLE, core_idx=0, cnt_idx=0.
//  Interrupt bits clear only by softrst_i or rstn_i, never by a later under-quota result.
//  mask_q==0 -> sum 0 -> no interrupt, even with limit 0.
//  N_CORES=1: core_idx is constant 0, done_core_o is 1 bit wide at 0.
// TESTING
//  (N_CORES=2, N_COUNTERS=4, REG_WIDTH=8)
//  1 Assert rstn_i=0 mid-ACCUM -> all outputs 0 immediately; FSM IDLE; no done_o until en_i=1.
//  2 Counters {10,20,30,40}, mask0=4'b0101, lim0=39, mask1=0, lim1=0, en_i=1
//    -> done_o 6 cycles after enable with core 0, sum_o=40, intr[0]=1;
//    -> 6 cycles later: core 1, sum_o=0, intr[1]=0.
//  3 As test 2 with lim0=40 -> sum_o=40, intr[0]=0 (equality is not over quota).
//  4 All counters 255, mask0=4'hF, lim0=255 -> sum_o=1020 (10-bit, no wrap), intr[0]=1.
//  5 After intr[0]=1, set counters to 0 -> intr[0] stays 1;
//    pulse softrst_i -> intr=0, done_o=0, next done_o 6 cycles after softrst release.
//  6 Drop en_i during core 0 ACCUM, or change mask0 mid-ACCUM ->
//    abort: no done_o, re-enable restarts at core 0;
//    mask change: current sum uses old mask, next core-0 check uses new mask.

Source files
------------

// File: rtl/pmu_quota_sched.sv
// pmu_quota_sched: round-robin quota checker sharing one accumulator across cores,
// raising a sticky interrupt when a core's masked counter sum exceeds its limit.
module pmu_quota_sched #(
    parameter int REG_WIDTH  = 32,
    parameter int N_COUNTERS = 9,
    parameter int N_CORES    = 4,
    localparam int SUM_W = REG_WIDTH + $clog2(N_COUNTERS),
    localparam int CIW   = (N_CORES > 1) ? $clog2(N_CORES) : 1,
    localparam int CNW   = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rstn_i,
    input  logic                                   en_i,
    input  logic                                   softrst_i,
    input  logic [N_COUNTERS-1:0][REG_WIDTH-1:0]   counter_value_i,
    input  logic [N_CORES-1:0][REG_WIDTH-1:0]      quota_limit_i,
    input  logic [N_CORES-1:0][N_COUNTERS-1:0]     quota_mask_i,
    output logic [N_CORES-1:0]                     intr_quota_o,
    output logic                                   done_o,
    output logic [CIW-1:0]                         done_core_o,
    output logic [SUM_W-1:0]                       sum_o
);
    typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, CHECK} state_t;
    state_t                 state, state_nxt;
    logic [CIW-1:0]         core_idx;
    logic [CNW-1:0]         cnt_idx;
    logic [SUM_W-1:0]       acc;
    logic [N_COUNTERS-1:0]  mask_q;
    logic [REG_WIDTH-1:0]   lim_q;
    logic                   last_cnt;
    logic                   last_core;
    assign last_cnt  = (cnt_idx == CNW'(N_COUNTERS - 1));
    assign last_core = (core_idx == CIW'(N_CORES - 1));
    always_comb begin
        state_nxt = state;
        if (softrst_i || !en_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  state_nxt = CLEAR;
                CLEAR: state_nxt = ACCUM;
                ACCUM: state_nxt = last_cnt ? CHECK : ACCUM;
                CHECK: state_nxt = CLEAR;
            endcase
        end
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_nxt;
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            core_idx     <= '0;
            cnt_idx      <= '0;
            acc          <= '0;
            mask_q       <= '0;
            lim_q        <= '0;
            intr_quota_o <= '0;
            done_o       <= 1'b0;
            done_core_o  <= '0;
            sum_o        <= '0;
        end else if (softrst_i) begin
            core_idx     <= '0;
            cnt_idx      <= '0;
            acc          <= '0;
            intr_quota_o <= '0;
            done_o       <= 1'b0;
            done_core_o  <= '0;
            sum_o        <= '0;
        end else begin
            done_o <= 1'b0;
            // Disabling abandons the in-flight check; the next enable starts at core 0.
            if (!en_i) begin
                core_idx <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    CLEAR: begin
                        acc     <= '0;
                        cnt_idx <= '0;
                        mask_q  <= quota_mask_i[core_idx];
                        lim_q   <= quota_limit_i[core_idx];
                    end
                    ACCUM: begin
                        acc     <= acc + (mask_q[cnt_idx] ? SUM_W'(counter_value_i[cnt_idx]) : '0);
                        cnt_idx <= last_cnt ? cnt_idx : cnt_idx + CNW'(1);
                    end
                    CHECK: begin
                        intr_quota_o[core_idx] <= intr_quota_o[core_idx] | (acc > SUM_W'(lim_q));
                        done_o      <= 1'b1;
                        done_core_o <= core_idx;
                        sum_o       <= acc;
                        core_idx    <= last_core ? '0 : core_idx + CIW'(1);
                    end
                endcase
            end
        end
    end
endmodule
